if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage that drives the instruction memory address and captures the returned word into the IF/ID pipeline register. It holds the program counter, advances it by 4 each accepted cycle, and accepts a redirect (branch/jump) from later stages. It stalls under backpressure from decode and stops fetching when the PC leaves the instruction-memory range. It sits directly upstream of the byte-addressed, big-endian, combinational-read instruction memory and directly upstream of decode.

## Interface
- IMEM_BYTES, 128, instruction-memory size in bytes; the fetch range is 0 .. IMEM_BYTES-4.
- RESET_PC, 0, PC value after reset; must be a multiple of 4.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- instr_addr  out  32  byte address to instruction memory; equals the PC, combinational from the PC register.
- instruction  in  32  word returned combinationally by instruction memory for instr_addr.
- redirect_valid  in  1  next-PC override this cycle; also flushes IF/ID.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- id_ready  in  1  decode accepts id_* this cycle.
- id_valid  out  1  the IF/ID register holds a valid instruction.
- id_instr  out  32  captured instruction word.
- id_pc  out  32  PC of id_instr.
- id_pc_plus4  out  32  id_pc + 4, registered.
- fetch_done  out  1  PC is out of range; no fetch occurs.

## Operation
- `in_range` = (33-bit pc + 4) <= IMEM_BYTES. Use a 33-bit compare so there is no wrap at 0xFFFFFFFC.
- `fetch_done` = !in_range. It is combinational from the PC and is deasserted during reset.
- `stall` = id_valid && !id_ready.
- State is implied by the registers:
  - FETCH: in_range and !stall.
  - HOLD: stall.
  - DONE: !in_range and !stall.
- Each rising edge applies the first matching rule in this priority order:
  1. rst: pc <= RESET_PC; id_valid <= 0; id_instr, id_pc, id_pc_plus4 <= 0.
  2. redirect_valid: pc <= {redirect_pc[31:2], 2'b00}; id_valid <= 0; the other id_* fields hold. Redirect overrides stall, and any held instruction is discarded.
  3. stall: pc and all id_* hold.
  4. in_range: id_instr <= instruction; id_pc <= pc; id_pc_plus4 <= pc + 4; id_valid <= 1; pc <= pc + 4.
  5. otherwise (DONE): id_valid <= 0; pc holds.
- A redirect to an in-range target leaves DONE. A redirect to an out-of-range target enters DONE.
- PC arithmetic is 32-bit modulo. The range check prevents any increment past the end of memory.

## Timing
- Reset values: instr_addr = RESET_PC; id_valid = 0; id_instr = id_pc = id_pc_plus4 = 0; fetch_done = 0 for a legal RESET_PC.
- Fetch latency:
  - The address is presented in cycle N and the word appears on id_* after edge N.
  - Throughput is 1 instruction per cycle with no bubbles when id_ready is held high.
- First valid after reset: the edge after rst falls gives id_valid = 1 and id_pc = RESET_PC.
- Redirect asserted in cycle N:
  - After edge N: instr_addr = target and id_valid = 0 (one bubble).
  - After edge N+1: id_pc = target.
- Stall: id_* are stable while id_valid && !id_ready. The handshake completes on an edge where id_valid && id_ready.
- id_ready is ignored when id_valid = 0. A bubble never blocks fetch.
- Reset asserted mid-stall or mid-redirect takes priority and completes in one edge.

## Test plan
- Reset then free-run with id_ready = 1, memory holding words 0x00000013 + 4k at byte 4k:
  - id_pc = 0, 4, 8, … on consecutive edges.
  - id_instr matches the word at id_pc; id_pc_plus4 = id_pc + 4.
- Run to the end of memory (IMEM_BYTES = 128):
  - Last valid id_pc = 124.
  - Next edge: id_valid = 0, fetch_done = 1, instr_addr holds 128.
- Stall: drop id_ready for 3 cycles while id_pc = 8.
  - id_pc stays 8 and instr_addr stays 12 throughout.
  - After release: id_pc = 12 on the next edge, with no lost or duplicated instruction.
- Redirect while stalled: id_valid = 1, id_ready = 0, redirect_valid = 1, redirect_pc = 0x22.
  - Next cycle: id_valid = 0, instr_addr = 0x20.
  - Following edge: id_pc = 0x20.
- Redirect out of and back into range:
  - redirect_pc = 0xFFFFFFFC gives fetch_done = 1 and no wrap.
  - A later redirect_pc = 0x10 clears fetch_done and gives id_pc = 0x10.
- Reset asserted mid-stream at id_pc = 40: on the next edge id_valid = 0, instr_addr = 0, and fetch restarts from 0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, drives instruction memory, fills the IF/ID register.
// Latency: address presented in cycle N, word visible on id_* after edge N; 1 instr/cycle.
// Backpressure: id_valid && !id_ready freezes PC and id_*; a redirect overrides the stall.
module if_stage #(
    parameter int unsigned IMEM_BYTES = 128,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instr_addr,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_done
);

    // One past the last byte a full word may occupy; compared in 33 bits so the
    // PC + 4 at 0xFFFFFFFC does not wrap back into range.
    localparam logic [32:0] FETCH_LIMIT = 33'(IMEM_BYTES);

    // The state is not stored; it is a view of the PC and IF/ID valid registers.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DONE  = 2'd2
    } fetch_state_t;

    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic         in_range;
    logic         stall;
    fetch_state_t state;

    logic [31:0]  pc_next;
    logic         id_valid_next;
    logic [31:0]  id_instr_next;
    logic [31:0]  id_pc_next;
    logic [31:0]  id_pc_plus4_next;

    assign pc_plus4   = pc + 32'd4;
    assign in_range   = ({1'b0, pc} + 33'd4) <= FETCH_LIMIT;
    assign stall      = id_valid && !id_ready;
    assign instr_addr = pc;
    // Held low while reset is applied so a stale out-of-range PC never leaks out.
    assign fetch_done = !in_range && !rst;

    // Derive the implied fetch state from the registers.
    always_comb begin
        state = DONE;
        if (stall) begin
            state = HOLD;
        end else if (in_range) begin
            state = FETCH;
        end
    end

    // Next-value logic: redirect first, then the implied state decides.
    always_comb begin
        pc_next          = pc;
        id_valid_next    = id_valid;
        id_instr_next    = id_instr;
        id_pc_next       = id_pc;
        id_pc_plus4_next = id_pc_plus4;

        if (redirect_valid) begin
            // Word-align the target; the held instruction, if any, is squashed.
            pc_next       = redirect_pc & ~32'd3;
            id_valid_next = 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    id_instr_next    = instruction;
                    id_pc_next       = pc;
                    id_pc_plus4_next = pc_plus4;
                    id_valid_next    = 1'b1;
                    pc_next          = pc_plus4;
                end
                HOLD: begin
                    // Everything holds until decode takes the instruction.
                end
                DONE: begin
                    id_valid_next = 1'b0;
                end
                default: begin
                    id_valid_next = 1'b0;
                end
            endcase
        end
    end

    // PC and IF/ID pipeline register; reset wins over redirect and stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= 32'd0;
            id_pc       <= 32'd0;
            id_pc_plus4 <= 32'd0;
        end else begin
            pc          <= pc_next;
            id_valid    <= id_valid_next;
            id_instr    <= id_instr_next;
            id_pc       <= id_pc_next;
            id_pc_plus4 <= id_pc_plus4_next;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized traffic against a reference model.
// Latency: inputs change 1 time unit after each rising edge, outputs checked at the same point.
// Backpressure: id_ready driven directly by each scenario.
module tb_if_stage;

    localparam int unsigned IMEM_BYTES = 128;
    localparam int unsigned NWORDS     = IMEM_BYTES / 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_addr;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fetch_done;

    int checks = 0;
    int fails  = 0;

    // Memory: byte array feeds the DUT (big-endian), word array feeds the model.
    logic [7:0]  mem_bytes [IMEM_BYTES];
    logic [31:0] mem_words [NWORDS];

    // Reference model of the architectural state.
    longint      m_pc;
    bit          m_valid;
    logic [31:0] m_instr;
    longint      m_idpc;

    if_stage #(
        .IMEM_BYTES(IMEM_BYTES),
        .RESET_PC  (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_addr    (instr_addr),
        .instruction   (instruction),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_pc_plus4   (id_pc_plus4),
        .fetch_done    (fetch_done)
    );

    always #5 clk = ~clk;

    // Combinational big-endian instruction memory; zero outside the array.
    always @* begin
        instruction = 32'd0;
        if (!$isunknown(instr_addr) && (longint'(instr_addr) + 4 <= IMEM_BYTES))
            instruction = {mem_bytes[instr_addr], mem_bytes[instr_addr + 1],
                           mem_bytes[instr_addr + 2], mem_bytes[instr_addr + 3]};
    end

    task automatic set_word(input int k, input logic [31:0] w);
        mem_words[k]         = w;
        mem_bytes[4 * k]     = w[31:24];
        mem_bytes[4 * k + 1] = w[23:16];
        mem_bytes[4 * k + 2] = w[15:8];
        mem_bytes[4 * k + 3] = w[7:0];
    endtask

    function automatic bit model_in_range(input longint pc);
        return (pc + 4) <= longint'(IMEM_BYTES);
    endfunction

    // Apply one edge's worth of the fetch rules to the model, using the current inputs.
    task automatic model_step();
        if (rst) begin
            m_pc = 0; m_valid = 0; m_instr = 0; m_idpc = 0;
        end else if (redirect_valid) begin
            m_pc    = longint'(redirect_pc) - (longint'(redirect_pc) % 4);
            m_valid = 0;
        end else if (m_valid && !id_ready) begin
            // decode has not taken it yet
        end else if (model_in_range(m_pc)) begin
            m_instr = mem_words[m_pc / 4];
            m_idpc  = m_pc;
            m_valid = 1;
            m_pc    = m_pc + 4;
        end else begin
            m_valid = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; id_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; id_ready = 1'b0;
        tick();
        tick();
        checks++; if (instr_addr !== 32'd0) begin fails++; $display("FAIL reset_addr got %h want 00000000", instr_addr); end
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", id_valid); end
        checks++; if (id_instr !== 32'd0) begin fails++; $display("FAIL reset_instr got %h want 00000000", id_instr); end
        checks++; if (id_pc !== 32'd0) begin fails++; $display("FAIL reset_pc got %h want 00000000", id_pc); end
        checks++; if (id_pc_plus4 !== 32'd0) begin fails++; $display("FAIL reset_pc4 got %h want 00000000", id_pc_plus4); end
        checks++; if (fetch_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", fetch_done); end
        rst = 1'b0;
    endtask

    task automatic test_free_run_to_end();
        id_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            checks++; if (id_valid !== 1'b1) begin fails++; $display("FAIL run_valid[%0d] got %b want 1", i, id_valid); end
            checks++; if (id_pc !== 32'(4 * i)) begin fails++; $display("FAIL run_pc[%0d] got %h want %h", i, id_pc, 32'(4 * i)); end
            checks++; if (id_instr !== 32'(32'h13 + 4 * i)) begin fails++; $display("FAIL run_instr[%0d] got %h want %h", i, id_instr, 32'(32'h13 + 4 * i)); end
            checks++; if (id_pc_plus4 !== 32'(4 * i + 4)) begin fails++; $display("FAIL run_pc4[%0d] got %h want %h", i, id_pc_plus4, 32'(4 * i + 4)); end
        end
        checks++; if (fetch_done !== 1'b1) begin fails++; $display("FAIL end_done_early got %b want 1", fetch_done); end
        tick();
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL end_valid got %b want 0", id_valid); end
        checks++; if (fetch_done !== 1'b1) begin fails++; $display("FAIL end_done got %b want 1", fetch_done); end
        checks++; if (instr_addr !== 32'd128) begin fails++; $display("FAIL end_addr got %h want 00000080", instr_addr); end
        checks++; if (id_pc !== 32'd124) begin fails++; $display("FAIL end_last_pc got %h want 0000007c", id_pc); end
        tick();
        checks++; if (instr_addr !== 32'd128) begin fails++; $display("FAIL end_addr_hold got %h want 00000080", instr_addr); end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) tick();
        checks++; if (id_pc !== 32'd8) begin fails++; $display("FAIL stall_setup got %h want 00000008", id_pc); end
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (id_pc !== 32'd8) begin fails++; $display("FAIL stall_pc[%0d] got %h want 00000008", i, id_pc); end
            checks++; if (instr_addr !== 32'd12) begin fails++; $display("FAIL stall_addr[%0d] got %h want 0000000c", i, instr_addr); end
            checks++; if (id_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d] got %b want 1", i, id_valid); end
            checks++; if (id_instr !== 32'h1b) begin fails++; $display("FAIL stall_instr[%0d] got %h want 0000001b", i, id_instr); end
        end
        id_ready = 1'b1;
        tick();
        checks++; if (id_pc !== 32'd12) begin fails++; $display("FAIL release_pc got %h want 0000000c", id_pc); end
        checks++; if (id_instr !== 32'h1f) begin fails++; $display("FAIL release_instr got %h want 0000001f", id_instr); end
        tick();
        checks++; if (id_pc !== 32'd16) begin fails++; $display("FAIL release_next got %h want 00000010", id_pc); end
    endtask

    task automatic test_redirect_stalled();
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h22;
        checks++; if (id_valid !== 1'b1) begin fails++; $display("FAIL redir_setup got %b want 1", id_valid); end
        tick();
        redirect_valid = 1'b0;
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL redir_bubble got %b want 0", id_valid); end
        checks++; if (instr_addr !== 32'h20) begin fails++; $display("FAIL redir_addr got %h want 00000020", instr_addr); end
        // id_ready stays low: a bubble must not block fetch
        tick();
        checks++; if (id_pc !== 32'h20) begin fails++; $display("FAIL redir_pc got %h want 00000020", id_pc); end
        checks++; if (id_valid !== 1'b1) begin fails++; $display("FAIL redir_valid got %b want 1", id_valid); end
        checks++; if (id_instr !== 32'h33) begin fails++; $display("FAIL redir_instr got %h want 00000033", id_instr); end
        id_ready = 1'b1;
    endtask

    task automatic test_redirect_range();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fetch_done !== 1'b1) begin fails++; $display("FAIL oor_done got %b want 1", fetch_done); end
        checks++; if (instr_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL oor_addr got %h want fffffffc", instr_addr); end
        repeat (2) tick();
        checks++; if (instr_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL oor_nowrap got %h want fffffffc", instr_addr); end
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL oor_valid got %b want 0", id_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fetch_done !== 1'b0) begin fails++; $display("FAIL back_done got %b want 0", fetch_done); end
        tick();
        checks++; if (id_pc !== 32'h10) begin fails++; $display("FAIL back_pc got %h want 00000010", id_pc); end
        checks++; if (id_valid !== 1'b1) begin fails++; $display("FAIL back_valid got %b want 1", id_valid); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        repeat (11) tick();
        checks++; if (id_pc !== 32'd40) begin fails++; $display("FAIL mid_setup got %h want 00000028", id_pc); end
        rst = 1'b1;
        tick();
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %b want 0", id_valid); end
        checks++; if (instr_addr !== 32'd0) begin fails++; $display("FAIL mid_addr got %h want 00000000", instr_addr); end
        rst = 1'b0;
        tick();
        checks++; if (id_pc !== 32'd0 || id_valid !== 1'b1) begin fails++; $display("FAIL mid_restart got pc=%h v=%b want pc=00000000 v=1", id_pc, id_valid); end
    endtask

    task automatic test_random_traffic();
        for (int k = 0; k < int'(NWORDS); k++) set_word(k, $urandom);
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst            = ($urandom_range(0, 63) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 140));
            id_ready       = ($urandom_range(0, 3) != 0);
            tick();
            checks++; if (instr_addr !== 32'(m_pc)) begin fails++; $display("FAIL rnd_addr[%0d] got %h want %h", cyc, instr_addr, 32'(m_pc)); end
            checks++; if (id_valid !== m_valid) begin fails++; $display("FAIL rnd_valid[%0d] got %b want %b", cyc, id_valid, m_valid); end
            checks++; if (id_instr !== m_instr) begin fails++; $display("FAIL rnd_instr[%0d] got %h want %h", cyc, id_instr, m_instr); end
            checks++; if (id_pc !== 32'(m_idpc)) begin fails++; $display("FAIL rnd_pc[%0d] got %h want %h", cyc, id_pc, 32'(m_idpc)); end
            checks++; if (id_pc_plus4 !== 32'(m_idpc + 4) && !(m_idpc == 0 && !m_valid && id_pc_plus4 === 32'd0))
                begin fails++; $display("FAIL rnd_pc4[%0d] got %h want %h", cyc, id_pc_plus4, 32'(m_idpc + 4)); end
            checks++; if (fetch_done !== (!rst && !model_in_range(m_pc))) begin fails++; $display("FAIL rnd_done[%0d] got %b want %b", cyc, fetch_done, (!rst && !model_in_range(m_pc))); end
        end
        rst = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < int'(NWORDS); k++) set_word(k, 32'(32'h13 + 4 * k));
        m_pc = 0; m_valid = 0; m_instr = 0; m_idpc = 0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; id_ready = 1'b1;
        #1;
        test_reset();
        test_free_run_to_end();
        test_stall();
        test_redirect_stalled();
        test_redirect_range();
        test_reset_midstream();
        test_random_traffic();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
